decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised successor to the control-code decoder: decodes 32-bit MIPS instructions into ALU and control codes, tags each one with a wrapping sequence number, and buffers the results in a DEPTH-entry FIFO with valid/ready handshakes on both sides. It sits between instruction fetch and execute, absorbing execute stalls and supporting pipeline flush.

## Interface
- ALU_W, 8, alu_code width; codes from `alucode_defines.v`
- CTRL_W, 9, ctrl_code width; codes from `alucode_defines.v`
- DEPTH, 4, FIFO entries; power of two, ≥2
- TAG_W, 4, sequence-tag width
- clk  in  1  clock; one clock domain
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  fetch presents inst
- in_ready  out  1  queue can accept
- inst  in  32  instruction word
- flush  in  1  drop all queued and incoming entries
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes head
- alu_code  out  ALU_W  head ALU code
- ctrl_code  out  CTRL_W  head control code
- out_invalid  out  1  head instruction undecodable
- out_tag  out  TAG_W  head sequence tag
- occupancy  out  $clog2(DEPTH)+1  entries held
- invalid_cnt  out  16  saturating count of accepted invalid instructions

## Operation
- Accept when in_valid && in_ready && !flush; pop when out_valid && out_ready && !flush.
- Decode is combinational on inst at accept; {alu_code, ctrl_code, invalid, tag} written to tail entry.
- Primary opcode inst[31:26]: ADDI 08, ADDIU 09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, XORI 0E, LUI 0F, BEQ 04, BNE 05, LW 23, SW 2B, PREF 33, SPECIAL 00 → matching `*_CODE`/`*_CTRL`.
- SPECIAL, funct inst[5:0]: SLL 00, SRL 02, SRA 03, SLLV 04, SRLV 06, SRAV 07, JR 08, SYNC 0F, ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, XOR 26, NOR 27, SLT 2A, SLTU 2B.
- SLL/SRL/SRA valid only if inst[25:21]==0; all other SPECIAL ops valid only if inst[10:6]==0 (SYNC excepted: stype ignored).
- Anything else: `INVALID_CODE`/`INVALID_CTRL`, invalid=1; still queued (execute raises reserved-instruction exception).
- Tag counter: increments by 1 per accepted instruction, wraps 2^TAG_W−1 → 0; flush does not reset it.
- invalid_cnt: +1 per accepted invalid instruction, saturates at 0xFFFF; cleared only by rst.

## Timing
- Reset (rst=1 at clk edge): queue empty, tag=0, invalid_cnt=0; in_ready=1 the cycle after, out_valid=0.
- When empty: alu_code=`RST_CODE`, ctrl_code=`RST_CTRL`, out_invalid=0, out_tag=0.
- Latency: inst accepted at edge N appears on outputs after edge N (out_valid=1 in cycle N+1); no combinational in→out path.
- in_ready = (occupancy < DEPTH); registered-state only, no dependence on out_ready.
- Full with simultaneous pop: in_ready stays 0 that cycle; slot reusable next cycle.
- Simultaneous push and pop (not full): occupancy unchanged, order preserved.
- out_valid held with stable payload until popped.
- flush: after edge, occupancy=0, out_valid=0; concurrent input is dropped (not tagged, not counted); rst has priority over flush.
- Pointers wrap modulo DEPTH.

## Configuration
- DECODE_MULDIV_EN defined: SPECIAL funct MULT 18, MULTU 19, DIV 1A, DIVU 1B (inst[15:6]==0), MFHI 10, MFLO 12 (inst[25:16]==0, inst[10:6]==0) decode to `MULT_CODE`…`MFLO_CODE` and matching `*_CTRL`, invalid=0.
- Undefined: those functs decode as invalid and increment invalid_cnt.

## Test plan
- Reset then inst=0x20080005 (ADDI), out_ready=1 → next cycle out_valid=1, alu_code=`ADDI_CODE`, out_tag=0, out_invalid=0.
- out_ready=0, push 5 valid insts with DEPTH=4 → in_ready drops after 4th, occupancy=4, 5th held by fetch; release → tags 0,1,2,3,4 in order.
- inst=0x00221000 (SLL, rs≠0) and 0xFC000000 → both out_invalid=1, `INVALID_CODE`, invalid_cnt=2.
- Push 17 insts with TAG_W=4 → 17th carries out_tag=0 (wrap).
- Queue holding 3 entries, flush=1 with in_valid=1 → next cycle occupancy=0, out_valid=0; following accepted inst gets tag 3.
- inst=0x0043001A (DIV) → with DECODE_MULDIV_EN `DIV_CODE`, out_invalid=0; without, out_invalid=1.

Source files
------------

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : decode_queue
// Purpose  : MIPS instruction decoder with sequence tagging, feeding a
//            DEPTH-entry valid/ready FIFO between fetch and execute.
// Options  : DECODE_MULDIV_EN adds MULT/MULTU/DIV/DIVU/MFHI/MFLO decode.
// Revision : 1.0 - initial release
// ============================================================================
module decode_queue #(
  parameter int ALU_W  = 8,
  parameter int CTRL_W = 9,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ALU_W-1:0]         alu_code,
  output logic [CTRL_W-1:0]        ctrl_code,
  output logic                     out_invalid,
  output logic [TAG_W-1:0]         out_tag,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              invalid_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int ENT_W = 1 + TAG_W + CTRL_W + ALU_W;

  localparam logic [7:0] RST_CODE = 8'h00, INVALID_CODE = 8'hFF;
  localparam logic [7:0] ADDI_CODE = 8'h01, ADDIU_CODE = 8'h02, SLTI_CODE = 8'h03, SLTIU_CODE = 8'h04;
  localparam logic [7:0] ANDI_CODE = 8'h05, ORI_CODE = 8'h06, XORI_CODE = 8'h07, LUI_CODE = 8'h08;
  localparam logic [7:0] BEQ_CODE = 8'h09, BNE_CODE = 8'h0A, LW_CODE = 8'h0B, SW_CODE = 8'h0C, PREF_CODE = 8'h0D;
  localparam logic [7:0] SLL_CODE = 8'h10, SRL_CODE = 8'h11, SRA_CODE = 8'h12, SLLV_CODE = 8'h13;
  localparam logic [7:0] SRLV_CODE = 8'h14, SRAV_CODE = 8'h15, JR_CODE = 8'h16, SYNC_CODE = 8'h17;
  localparam logic [7:0] ADD_CODE = 8'h18, ADDU_CODE = 8'h19, SUB_CODE = 8'h1A, SUBU_CODE = 8'h1B;
  localparam logic [7:0] AND_CODE = 8'h1C, OR_CODE = 8'h1D, XOR_CODE = 8'h1E, NOR_CODE = 8'h1F;
  localparam logic [7:0] SLT_CODE = 8'h20, SLTU_CODE = 8'h21;

  // Control bits: [8] sign-extend imm, [7] shamt, [6] hi/lo, [5] jump,
  // [4] branch, [3] mem write, [2] mem read, [1] imm operand, [0] reg write.
  localparam logic [8:0] RST_CTRL = 9'h000, INVALID_CTRL = 9'h1FF;
  localparam logic [8:0] ADDI_CTRL = 9'h103, ADDIU_CTRL = 9'h103, SLTI_CTRL = 9'h103, SLTIU_CTRL = 9'h103;
  localparam logic [8:0] ANDI_CTRL = 9'h003, ORI_CTRL = 9'h003, XORI_CTRL = 9'h003, LUI_CTRL = 9'h003;
  localparam logic [8:0] BEQ_CTRL = 9'h110, BNE_CTRL = 9'h110, LW_CTRL = 9'h107, SW_CTRL = 9'h10A, PREF_CTRL = 9'h102;
  localparam logic [8:0] SLL_CTRL = 9'h081, SRL_CTRL = 9'h081, SRA_CTRL = 9'h081, SLLV_CTRL = 9'h001;
  localparam logic [8:0] SRLV_CTRL = 9'h001, SRAV_CTRL = 9'h001, JR_CTRL = 9'h020, SYNC_CTRL = 9'h000;
  localparam logic [8:0] ADD_CTRL = 9'h001, ADDU_CTRL = 9'h001, SUB_CTRL = 9'h001, SUBU_CTRL = 9'h001;
  localparam logic [8:0] AND_CTRL = 9'h001, OR_CTRL = 9'h001, XOR_CTRL = 9'h001, NOR_CTRL = 9'h001;
  localparam logic [8:0] SLT_CTRL = 9'h001, SLTU_CTRL = 9'h001;
`ifdef DECODE_MULDIV_EN
  localparam logic [7:0] MULT_CODE = 8'h28, MULTU_CODE = 8'h29, DIV_CODE = 8'h2A, DIVU_CODE = 8'h2B;
  localparam logic [7:0] MFHI_CODE = 8'h2C, MFLO_CODE = 8'h2D;
  localparam logic [8:0] MULT_CTRL = 9'h040, MULTU_CTRL = 9'h040, DIV_CTRL = 9'h040, DIVU_CTRL = 9'h040;
  localparam logic [8:0] MFHI_CTRL = 9'h041, MFLO_CTRL = 9'h041;
`endif

  logic [5:0]  w_op, w_funct;
  logic        w_rs_zero, w_sa_zero;
  logic [17:0] w_dec;  // {invalid, ctrl[8:0], alu[7:0]}
  logic        w_push, w_pop;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [15:0]      inv_cnt_q, inv_cnt_d;
  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] w_head;

  assign w_op      = inst[31:26];
  assign w_funct   = inst[5:0];
  assign w_rs_zero = (inst[25:21] == 5'd0);
  assign w_sa_zero = (inst[10:6] == 5'd0);

`ifdef DECODE_MULDIV_EN
  logic w_md_zero, w_mf_zero;
  assign w_md_zero = (inst[15:6] == 10'd0);
  assign w_mf_zero = (inst[25:16] == 10'd0) && w_sa_zero;
`else
  logic w_unused_fields;
  assign w_unused_fields = ^inst[20:11];
`endif

  always_comb begin
    w_dec = {1'b1, INVALID_CTRL, INVALID_CODE};
    case (w_op)
      6'h08: w_dec = {1'b0, ADDI_CTRL, ADDI_CODE};
      6'h09: w_dec = {1'b0, ADDIU_CTRL, ADDIU_CODE};
      6'h0A: w_dec = {1'b0, SLTI_CTRL, SLTI_CODE};
      6'h0B: w_dec = {1'b0, SLTIU_CTRL, SLTIU_CODE};
      6'h0C: w_dec = {1'b0, ANDI_CTRL, ANDI_CODE};
      6'h0D: w_dec = {1'b0, ORI_CTRL, ORI_CODE};
      6'h0E: w_dec = {1'b0, XORI_CTRL, XORI_CODE};
      6'h0F: w_dec = {1'b0, LUI_CTRL, LUI_CODE};
      6'h04: w_dec = {1'b0, BEQ_CTRL, BEQ_CODE};
      6'h05: w_dec = {1'b0, BNE_CTRL, BNE_CODE};
      6'h23: w_dec = {1'b0, LW_CTRL, LW_CODE};
      6'h2B: w_dec = {1'b0, SW_CTRL, SW_CODE};
      6'h33: w_dec = {1'b0, PREF_CTRL, PREF_CODE};
      6'h00: begin
        // Immediate shifts reuse the shamt field, so they check rs instead.
        case (w_funct)
          6'h00: if (w_rs_zero) w_dec = {1'b0, SLL_CTRL, SLL_CODE};
          6'h02: if (w_rs_zero) w_dec = {1'b0, SRL_CTRL, SRL_CODE};
          6'h03: if (w_rs_zero) w_dec = {1'b0, SRA_CTRL, SRA_CODE};
          6'h04: if (w_sa_zero) w_dec = {1'b0, SLLV_CTRL, SLLV_CODE};
          6'h06: if (w_sa_zero) w_dec = {1'b0, SRLV_CTRL, SRLV_CODE};
          6'h07: if (w_sa_zero) w_dec = {1'b0, SRAV_CTRL, SRAV_CODE};
          6'h08: if (w_sa_zero) w_dec = {1'b0, JR_CTRL, JR_CODE};
          6'h0F: w_dec = {1'b0, SYNC_CTRL, SYNC_CODE};
          6'h20: if (w_sa_zero) w_dec = {1'b0, ADD_CTRL, ADD_CODE};
          6'h21: if (w_sa_zero) w_dec = {1'b0, ADDU_CTRL, ADDU_CODE};
          6'h22: if (w_sa_zero) w_dec = {1'b0, SUB_CTRL, SUB_CODE};
          6'h23: if (w_sa_zero) w_dec = {1'b0, SUBU_CTRL, SUBU_CODE};
          6'h24: if (w_sa_zero) w_dec = {1'b0, AND_CTRL, AND_CODE};
          6'h25: if (w_sa_zero) w_dec = {1'b0, OR_CTRL, OR_CODE};
          6'h26: if (w_sa_zero) w_dec = {1'b0, XOR_CTRL, XOR_CODE};
          6'h27: if (w_sa_zero) w_dec = {1'b0, NOR_CTRL, NOR_CODE};
          6'h2A: if (w_sa_zero) w_dec = {1'b0, SLT_CTRL, SLT_CODE};
          6'h2B: if (w_sa_zero) w_dec = {1'b0, SLTU_CTRL, SLTU_CODE};
`ifdef DECODE_MULDIV_EN
          6'h18: if (w_md_zero) w_dec = {1'b0, MULT_CTRL, MULT_CODE};
          6'h19: if (w_md_zero) w_dec = {1'b0, MULTU_CTRL, MULTU_CODE};
          6'h1A: if (w_md_zero) w_dec = {1'b0, DIV_CTRL, DIV_CODE};
          6'h1B: if (w_md_zero) w_dec = {1'b0, DIVU_CTRL, DIVU_CODE};
          6'h10: if (w_mf_zero) w_dec = {1'b0, MFHI_CTRL, MFHI_CODE};
          6'h12: if (w_mf_zero) w_dec = {1'b0, MFLO_CTRL, MFLO_CODE};
`endif
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign in_ready  = (occ_q < OCC_W'(DEPTH));
  assign out_valid = (occ_q != '0);
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    occ_d     = occ_q;
    tag_d     = tag_q;
    inv_cnt_d = inv_cnt_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        tag_d    = tag_q + TAG_W'(1);
        if (w_dec[17] && (inv_cnt_q != 16'hFFFF)) inv_cnt_d = inv_cnt_q + 16'd1;
      end
      if (w_pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(w_push) - OCC_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      occ_q     <= '0;
      tag_q     <= '0;
      inv_cnt_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      occ_q     <= occ_d;
      tag_q     <= tag_d;
      inv_cnt_q <= inv_cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {w_dec[17], tag_q, CTRL_W'(w_dec[16:8]), ALU_W'(w_dec[7:0])};
    end
  end

  assign w_head = mem_q[rd_ptr_q];

  always_comb begin
    alu_code    = ALU_W'(RST_CODE);
    ctrl_code   = CTRL_W'(RST_CTRL);
    out_invalid = 1'b0;
    out_tag     = '0;
    if (out_valid) begin
      alu_code    = w_head[ALU_W-1:0];
      ctrl_code   = w_head[ALU_W +: CTRL_W];
      out_tag     = w_head[ALU_W+CTRL_W +: TAG_W];
      out_invalid = w_head[ENT_W-1];
    end
  end

  assign occupancy   = occ_q;
  assign invalid_cnt = inv_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_queue.sv
`default_nettype none
// tb_decode_queue: directed and random stimulus compared against a
// table-driven decode model and a queue-based FIFO model.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready, out_invalid;
  logic [31:0] inst;
  logic [7:0]  alu_code;
  logic [8:0]  ctrl_code;
  logic [3:0]  out_tag;
  logic [2:0]  occupancy;
  logic [15:0] invalid_cnt;

  always #5 clk = ~clk;

  decode_queue #(.ALU_W(8), .CTRL_W(9), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .alu_code(alu_code),
    .ctrl_code(ctrl_code), .out_invalid(out_invalid), .out_tag(out_tag),
    .occupancy(occupancy), .invalid_cnt(invalid_cnt)
  );

  typedef struct {
    logic [7:0] alu;
    logic [8:0] ctrl;
    logic       inv;
    logic [3:0] tag;
  } ent_t;

  int   errors = 0;
  int   checks = 0;
  ent_t q[$];
  int   m_tag, m_cnt;

  // Decode tables; rule: 0 reserved, 1 rs==0, 2 shamt==0, 3 always,
  // 4 inst[15:6]==0, 5 inst[25:16]==0 and shamt==0.
  logic [7:0] op_alu[64];
  logic [8:0] op_ctrl[64];
  bit         op_ok[64];
  logic [7:0] fn_alu[64];
  logic [8:0] fn_ctrl[64];
  int         fn_rule[64];

  task automatic set_op(input int op, input logic [7:0] a, input logic [8:0] c);
    op_alu[op] = a; op_ctrl[op] = c; op_ok[op] = 1'b1;
  endtask

  task automatic set_fn(input int fn, input logic [7:0] a, input logic [8:0] c, input int rule);
    fn_alu[fn] = a; fn_ctrl[fn] = c; fn_rule[fn] = rule;
  endtask

  task automatic build_tables();
    for (int i = 0; i < 64; i++) begin
      op_ok[i] = 1'b0; op_alu[i] = 8'hFF; op_ctrl[i] = 9'h1FF;
      fn_rule[i] = 0; fn_alu[i] = 8'hFF; fn_ctrl[i] = 9'h1FF;
    end
    set_op(8, 8'h01, 9'h103);  set_op(9, 8'h02, 9'h103);  set_op(10, 8'h03, 9'h103);
    set_op(11, 8'h04, 9'h103); set_op(12, 8'h05, 9'h003); set_op(13, 8'h06, 9'h003);
    set_op(14, 8'h07, 9'h003); set_op(15, 8'h08, 9'h003); set_op(4, 8'h09, 9'h110);
    set_op(5, 8'h0A, 9'h110);  set_op(35, 8'h0B, 9'h107); set_op(43, 8'h0C, 9'h10A);
    set_op(51, 8'h0D, 9'h102);
    set_fn(0, 8'h10, 9'h081, 1);  set_fn(2, 8'h11, 9'h081, 1);  set_fn(3, 8'h12, 9'h081, 1);
    set_fn(4, 8'h13, 9'h001, 2);  set_fn(6, 8'h14, 9'h001, 2);  set_fn(7, 8'h15, 9'h001, 2);
    set_fn(8, 8'h16, 9'h020, 2);  set_fn(15, 8'h17, 9'h000, 3);
    for (int i = 0; i < 8; i++) set_fn(32 + i, 8'h18 + 8'(i), 9'h001, 2);
    set_fn(42, 8'h20, 9'h001, 2); set_fn(43, 8'h21, 9'h001, 2);
`ifdef DECODE_MULDIV_EN
    for (int i = 0; i < 4; i++) set_fn(24 + i, 8'h28 + 8'(i), 9'h040, 4);
    set_fn(16, 8'h2C, 9'h041, 5); set_fn(18, 8'h2D, 9'h041, 5);
`endif
  endtask

  function automatic ent_t ref_decode(input logic [31:0] w);
    ent_t e;
    int   op, fn;
    bit   ok;
    op = int'(w[31:26]);
    fn = int'(w[5:0]);
    e.alu = 8'hFF; e.ctrl = 9'h1FF; e.inv = 1'b1; e.tag = 4'd0;
    if (op != 0) begin
      ok = op_ok[op];
      if (ok) begin e.alu = op_alu[op]; e.ctrl = op_ctrl[op]; end
    end else begin
      case (fn_rule[fn])
        1:       ok = (w[25:21] == 5'd0);
        2:       ok = (w[10:6] == 5'd0);
        3:       ok = 1'b1;
        4:       ok = (w[15:6] == 10'd0);
        5:       ok = (w[25:16] == 10'd0) && (w[10:6] == 5'd0);
        default: ok = 1'b0;
      endcase
      if (ok) begin e.alu = fn_alu[fn]; e.ctrl = fn_ctrl[fn]; end
    end
    e.inv = !ok;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    chk("occupancy", 32'(occupancy), 32'(q.size()));
    chk("invalid_cnt", 32'(invalid_cnt), 32'(m_cnt));
    if (q.size() > 0) begin
      chk("alu_code", 32'(alu_code), 32'(q[0].alu));
      chk("ctrl_code", 32'(ctrl_code), 32'(q[0].ctrl));
      chk("out_invalid", 32'(out_invalid), 32'(q[0].inv));
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
    end else begin
      chk("alu_code_empty", 32'(alu_code), 32'h00);
      chk("ctrl_code_empty", 32'(ctrl_code), 32'h000);
      chk("out_invalid_empty", 32'(out_invalid), 32'h0);
      chk("out_tag_empty", 32'(out_tag), 32'h0);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; inst = 32'h0; flush = 1'b0; out_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    q.delete(); m_tag = 0; m_cnt = 0;
    check_all();
  endtask

  task automatic cyc(input logic v, input logic [31:0] w, input logic f, input logic r);
    bit   acc, pop;
    ent_t e, dropped;
    in_valid = v; inst = w; flush = f; out_ready = r;
    acc = v && (q.size() < DEPTH) && !f;
    pop = (q.size() > 0) && r && !f;
    e = ref_decode(w);
    @(posedge clk); #2;
    if (f) q.delete();
    else begin
      if (pop) dropped = q.pop_front();
      if (acc) begin
        e.tag = m_tag[3:0];
        q.push_back(e);
        m_tag = (m_tag + 1) % (1 << TAG_W);
        if (e.inv && m_cnt < 65535) m_cnt++;
      end
    end
    check_all();
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    w = $urandom;
    if ($urandom_range(1, 0) == 1) w[31:26] = 6'h00;
    else if ($urandom_range(1, 0) == 1) w[31:26] = 6'($urandom_range(15, 4));
    if ($urandom_range(1, 0) == 1) w[10:6] = 5'd0;
    if ($urandom_range(1, 0) == 1) w[25:21] = 5'd0;
    if ($urandom_range(1, 0) == 1) w[20:16] = 5'd0;
    if ($urandom_range(1, 0) == 1) w[15:11] = 5'd0;
    return w;
  endfunction

  initial begin
    build_tables();
    do_reset();

    // Single ADDI, consumer ready
    cyc(1'b1, 32'h20080005, 1'b0, 1'b1);
    chk("addi_alu", 32'(alu_code), 32'h01);
    chk("addi_tag", 32'(out_tag), 32'h0);
    cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Fill to DEPTH with consumer stalled, fifth held by fetch
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h20080000 | 32'(i), 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_occ", 32'(occupancy), 32'h4);
    cyc(1'b1, 32'h20080004, 1'b0, 1'b1);
    chk("full_pop_no_accept", 32'(occupancy), 32'h3);
    cyc(1'b1, 32'h20080004, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b0, 1'b1);

    // Invalid instructions
    do_reset();
    cyc(1'b1, 32'h00221000, 1'b0, 1'b0);
    cyc(1'b1, 32'hFC000000, 1'b0, 1'b0);
    chk("inv_cnt2", 32'(invalid_cnt), 32'h2);
    chk("inv_head", 32'(out_invalid), 32'h1);
    chk("inv_alu", 32'(alu_code), 32'hFF);

    // Tag wrap
    do_reset();
    for (int i = 0; i < 17; i++) cyc(1'b1, 32'h34000000 | 32'(i), 1'b0, 1'b1);
    chk("tag_wrap", 32'(out_tag), 32'h0);

    // Flush with concurrent input
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h20080000, 1'b0, 1'b0);
    cyc(1'b1, 32'hFC000000, 1'b1, 1'b0);
    chk("flush_occ", 32'(occupancy), 32'h0);
    chk("flush_cnt", 32'(invalid_cnt), 32'h0);
    cyc(1'b1, 32'h20080001, 1'b0, 1'b0);
    chk("post_flush_tag", 32'(out_tag), 32'h3);

    // DIV
    do_reset();
    cyc(1'b1, 32'h0043001A, 1'b0, 1'b0);
`ifdef DECODE_MULDIV_EN
    chk("div_inv", 32'(out_invalid), 32'h0);
    chk("div_alu", 32'(alu_code), 32'h2A);
`else
    chk("div_inv", 32'(out_invalid), 32'h1);
    chk("div_cnt", 32'(invalid_cnt), 32'h1);
`endif

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(3, 0) != 0), rand_inst(),
          1'($urandom_range(40, 0) == 0), 1'($urandom_range(2, 0) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
